// File: rtl/mult_seq.sv
// mult_seq: parametrised sequential shift-add multiplier (A/Q/M registers, counter, sequencer).
// Latency: START accepted at edge 0, AQ updated and DONE pulsed after exactly WIDTH clocks.
// Backpressure: READY low while BUSY; START ignored then. Optional two's-complement mode: MULT_SEQ_SIGNED_EN.
module mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [WIDTH-1:0]     MULTIPLICAND,
    input  logic [WIDTH-1:0]     MULTIPLIER,
`ifdef MULT_SEQ_SIGNED_EN
    input  logic                 SIGNED,
`endif
    output logic [2*WIDTH-1:0]   AQ,
    output logic                 READY,
    output logic                 DONE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   aq_q, aq_d;
    logic                 done_q, done_d;

    // {C,A} for this iteration before the right shift; the top bit is the carry
    // (unsigned) or the sign of the extended sum (signed) and becomes A's new MSB.
    logic [WIDTH:0]       sum_w;
    logic [WIDTH-1:0]     a_sh_w;
    logic [WIDTH-1:0]     q_sh_w;
    logic                 last_w;

    assign last_w = (cnt_q == '0);

`ifdef MULT_SEQ_SIGNED_EN
    logic signed_q, signed_d;
    logic ext_a_w, ext_m_w;

    assign ext_a_w = signed_q & a_q[WIDTH-1];
    assign ext_m_w = signed_q & m_q[WIDTH-1];

    // Signed partial sum: sign-extended add, with the final multiplier bit
    // carrying negative weight so it subtracts M instead of adding it.
    always_comb begin
        sum_w = {ext_a_w, a_q};
        if (q_q[0]) begin
            if (signed_q && last_w) begin
                sum_w = {ext_a_w, a_q} - {ext_m_w, m_q};
            end else begin
                sum_w = {ext_a_w, a_q} + {ext_m_w, m_q};
            end
        end
    end
`else
    // Unsigned partial sum: full WIDTH+1-bit add keeps the carry.
    always_comb begin
        sum_w = {1'b0, a_q};
        if (q_q[0]) begin
            sum_w = {1'b0, a_q} + {1'b0, m_q};
        end
    end
`endif

    // One-position right shift of {C,A,Q}: carry/sign into A's MSB, A[0] into Q's MSB.
    always_comb begin
        a_sh_w = sum_w[WIDTH:1];
        q_sh_w = {sum_w[0], q_q[WIDTH-1:1]};
    end

    // Sequencer: operand latch in IDLE, one shift-add iteration per cycle in BUSY.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        aq_d     = aq_q;
        done_d   = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
        signed_d = signed_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    m_d      = MULTIPLICAND;
                    q_d      = MULTIPLIER;
                    a_d      = '0;
                    cnt_d    = CNT_W'(WIDTH - 1);
`ifdef MULT_SEQ_SIGNED_EN
                    signed_d = SIGNED;
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                a_d   = a_sh_w;
                q_d   = q_sh_w;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_w) begin
                    // Product becomes visible only once complete; AQ never shows partials.
                    aq_d    = {a_sh_w, q_sh_w};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; RESET overrides everything and aborts any multiply.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q  <= IDLE;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            aq_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            aq_q     <= aq_d;
            done_q   <= done_d;
`ifdef MULT_SEQ_SIGNED_EN
            signed_q <= signed_d;
`endif
        end
    end

    assign AQ    = aq_q;
    assign READY = (state_q == IDLE);
    assign DONE  = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed checks of mult_seq at WIDTH=4 and WIDTH=8 sharing one clock.
// Inputs driven and outputs sampled on the falling edge, away from the active edge.
// Expected products are hand-computed constants; the signed cases need MULT_SEQ_SIGNED_EN.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start8;
    logic [3:0]  m4, q4;
    logic [7:0]  m8, q8;
    logic        sgn4, sgn8;
    logic [7:0]  aq4;
    logic [15:0] aq8;
    logic        rdy4, rdy8, done4, done8;

    int checks = 0;
    int errors = 0;
    logic [15:0] last4 = 16'h0;
    logic [15:0] last8 = 16'h0;

    always #5 clk = ~clk;

    mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .RESET(rst), .START(start4),
        .MULTIPLICAND(m4), .MULTIPLIER(q4),
`ifdef MULT_SEQ_SIGNED_EN
        .SIGNED(sgn4),
`endif
        .AQ(aq4), .READY(rdy4), .DONE(done4)
    );

    mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .RESET(rst), .START(start8),
        .MULTIPLICAND(m8), .MULTIPLIER(q8),
`ifdef MULT_SEQ_SIGNED_EN
        .SIGNED(sgn8),
`endif
        .AQ(aq8), .READY(rdy8), .DONE(done8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_aq(input bit wide);
        return wide ? aq8 : {8'h00, aq4};
    endfunction

    function automatic logic get_rdy(input bit wide);
        return wide ? rdy8 : rdy4;
    endfunction

    function automatic logic get_done(input bit wide);
        return wide ? done8 : done4;
    endfunction

    // One complete operation checked cycle by cycle. With poke set, a START
    // with different operands is pulsed during BUSY and must be ignored.
    task automatic do_op(input bit wide, input logic [7:0] m, input logic [7:0] q,
                         input logic sgn, input logic [15:0] exp, input bit poke,
                         input string tag);
        int w;
        logic [15:0] prev;
        w    = wide ? 8 : 4;
        prev = wide ? last8 : last4;
        if (wide) begin
            m8 = m; q8 = q; sgn8 = sgn; start8 = 1'b1;
        end else begin
            m4 = m[3:0]; q4 = q[3:0]; sgn4 = sgn; start4 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        for (int c = 0; c <= w; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("%s c%0d ready", tag, c), {15'h0, get_rdy(wide)}, {15'h0, (c == w)});
            check($sformatf("%s c%0d done", tag, c), {15'h0, get_done(wide)}, {15'h0, (c == w)});
            check($sformatf("%s c%0d aq", tag, c), get_aq(wide), (c == w) ? exp : prev);
            if (poke && c == 1) begin
                m4 = 4'hF; q4 = 4'hF; m8 = 8'hFF; q8 = 8'hFF;
                if (wide) start8 = 1'b1; else start4 = 1'b1;
            end else begin
                start4 = 1'b0; start8 = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, " done drop"}, {15'h0, get_done(wide)}, 16'h0);
        check({tag, " aq hold"}, get_aq(wide), exp);
        if (wide) last8 = exp; else last4 = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        m4 = '0; q4 = '0; m8 = '0; q8 = '0;
        sgn4 = 1'b0; sgn8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances
        check("rst aq4", {8'h00, aq4}, 16'h0000);
        check("rst rdy4", {15'h0, rdy4}, 16'h1);
        check("rst done4", {15'h0, done4}, 16'h0);
        check("rst aq8", aq8, 16'h0000);
        check("rst rdy8", {15'h0, rdy8}, 16'h1);
        check("rst done8", {15'h0, done8}, 16'h0);

        // Basic products at WIDTH=4
        do_op(1'b0, 8'h05, 8'h07, 1'b0, 16'h0023, 1'b0, "5x7");
        do_op(1'b0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0, "15x15");
        do_op(1'b0, 8'h00, 8'h09, 1'b0, 16'h0000, 1'b0, "0x9");
        do_op(1'b0, 8'h02, 8'h05, 1'b0, 16'h000A, 1'b1, "2x5 poke");

        // Back-to-back with START held: DONE at edges 4 and 9 after the first accept
        m4 = 4'd3; q4 = 4'd4; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m4 = 4'd6; q4 = 4'd6;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("b2b c%0d done", c), {15'h0, done4}, {15'h0, (c == 4 || c == 9)});
            check($sformatf("b2b c%0d ready", c), {15'h0, rdy4}, {15'h0, (c == 4 || c == 9)});
            check($sformatf("b2b c%0d aq", c), {8'h00, aq4},
                  (c < 4) ? 16'h000A : ((c < 9) ? 16'h000C : 16'h0024));
            if (c == 5) begin
                m4 = 4'hF; q4 = 4'hF;
            end
            if (c == 9) start4 = 1'b0;
        end
        @(negedge clk);
        check("b2b idle done", {15'h0, done4}, 16'h0);
        check("b2b idle ready", {15'h0, rdy4}, 16'h1);
        last4 = 16'h0024;

        // Reset two cycles into an operation aborts it with no DONE
        m4 = 4'd5; q4 = 4'd7; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", {15'h0, rdy4}, 16'h1);
        check("abort aq", {8'h00, aq4}, 16'h0000);
        check("abort done", {15'h0, done4}, 16'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort quiet c%0d done", c), {15'h0, done4}, 16'h0);
        end
        last4 = 16'h0000;
        do_op(1'b0, 8'h02, 8'h03, 1'b0, 16'h0006, 1'b0, "2x3");

        // WIDTH=8 boundaries (this instance also went through the abort reset)
        do_op(1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, "w8 255x255");
        do_op(1'b1, 8'h80, 8'h02, 1'b0, 16'h0100, 1'b0, "w8 80x02");

`ifdef MULT_SEQ_SIGNED_EN
        do_op(1'b0, 8'h0D, 8'h05, 1'b1, 16'h00F1, 1'b0, "s -3x5");
        do_op(1'b0, 8'h08, 8'h08, 1'b1, 16'h0040, 1'b0, "s -8x-8");
        do_op(1'b0, 8'h0D, 8'h05, 1'b0, 16'h0041, 1'b0, "u 13x5");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
